vendor_display_scan: RTL and testbench



---
 rtl/vendor_display_scan.sv | 134 +++++++++++++
 tb/tb_vendor_display_scan.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/vendor_display_scan.sv
`default_nettype none
// ============================================================================
// Module   : vendor_display_scan
// Brief    : Two-bank 4-digit seven-segment scan driver for the vending
//            price / money / change display, with per-frame input snapshot.
// Revision : 1.0 - initial release
// ============================================================================

module vendor_display_scan #(
    parameter int DWELL      = 1,
    parameter int BLINK_HALF = 500
) (
    input  logic       clk_1kHz,
    input  logic       rstn,
    input  logic [7:0] dis_price,
    input  logic [7:0] dis_money,
    input  logic [7:0] dis_returned,
    input  logic       flash,
    input  logic       lamp_test,
    output logic [3:0] scan_en_0,
    output logic [3:0] scan_en_1,
    output logic [6:0] data_0_7seg,
    output logic [6:0] data_1_7seg
);

    localparam int c_dwell_w = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam int c_blink_w = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
    localparam logic [c_dwell_w-1:0] c_dwell_last = c_dwell_w'(DWELL - 1);
    localparam logic [c_blink_w-1:0] c_blink_last = c_blink_w'(BLINK_HALF - 1);
    localparam logic [6:0] c_seg_dash  = 7'h40;
    localparam logic [6:0] c_seg_blank = 7'h00;
    localparam logic [6:0] c_seg_all   = 7'h7F;

    logic [1:0]           r_idx;
    logic [c_dwell_w-1:0] r_dwell_cnt;
    logic [c_blink_w-1:0] r_blink_cnt;
    logic                 r_blink_ph;
    logic [7:0]           r_snap_p;
    logic [7:0]           r_snap_m;
    logic [7:0]           r_snap_r;

    logic [3:0] w_en;
    logic [6:0] w_seg_0;
    logic [6:0] w_seg_1;

    // Tens positions blank a zero; any non-BCD nibble shows a dash.
    function automatic logic [6:0] seg_decode(input logic [3:0] digit, input logic is_tens);
        logic [6:0] seg;
        case (digit)
            4'd0:    seg = is_tens ? c_seg_blank : 7'h3F;
            4'd1:    seg = 7'h06;
            4'd2:    seg = 7'h5B;
            4'd3:    seg = 7'h4F;
            4'd4:    seg = 7'h66;
            4'd5:    seg = 7'h6D;
            4'd6:    seg = 7'h7D;
            4'd7:    seg = 7'h07;
            4'd8:    seg = 7'h7F;
            4'd9:    seg = 7'h6F;
            default: seg = c_seg_dash;
        endcase
        return seg;
    endfunction

    always_comb begin
        w_en    = ~(4'b0001 << r_idx);
        w_seg_0 = c_seg_blank;
        w_seg_1 = c_seg_blank;
        case (r_idx)
            2'd0: begin
                w_seg_0 = seg_decode(r_snap_m[3:0], 1'b0);
                w_seg_1 = seg_decode(r_snap_r[3:0], 1'b0);
            end
            2'd1: begin
                w_seg_0 = seg_decode(r_snap_m[7:4], 1'b1);
                w_seg_1 = seg_decode(r_snap_r[7:4], 1'b1);
            end
            2'd2:    w_seg_0 = seg_decode(r_snap_p[3:0], 1'b0);
            default: w_seg_0 = seg_decode(r_snap_p[7:4], 1'b1);
        endcase
        if (flash && r_blink_ph) begin
            w_seg_1 = c_seg_blank;
        end
        if (lamp_test) begin
            w_en    = 4'b0000;
            w_seg_0 = c_seg_all;
            w_seg_1 = c_seg_all;
        end
    end

    always_ff @(posedge clk_1kHz) begin
        if (!rstn) begin
            r_idx       <= 2'd0;
            r_dwell_cnt <= '0;
            r_blink_cnt <= '0;
            r_blink_ph  <= 1'b0;
            r_snap_p    <= 8'h00;
            r_snap_m    <= 8'h00;
            r_snap_r    <= 8'h00;
            scan_en_0   <= 4'b1111;
            scan_en_1   <= 4'b1111;
            data_0_7seg <= c_seg_blank;
            data_1_7seg <= c_seg_blank;
        end else begin
            if (r_dwell_cnt == c_dwell_last) begin
                r_dwell_cnt <= '0;
                r_idx       <= r_idx + 2'd1;
                // Frame boundary: capture all three fields coherently.
                if (r_idx == 2'd3) begin
                    r_snap_p <= dis_price;
                    r_snap_m <= dis_money;
                    r_snap_r <= dis_returned;
                end
            end else begin
                r_dwell_cnt <= r_dwell_cnt + c_dwell_w'(1);
            end

            if (r_blink_cnt == c_blink_last) begin
                r_blink_cnt <= '0;
                r_blink_ph  <= ~r_blink_ph;
            end else begin
                r_blink_cnt <= r_blink_cnt + c_blink_w'(1);
            end

            scan_en_0   <= w_en;
            scan_en_1   <= w_en;
            data_0_7seg <= w_seg_0;
            data_1_7seg <= w_seg_1;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_vendor_display_scan.sv
`default_nettype none
// ============================================================================
// Module   : tb_vendor_display_scan
// Brief    : Self-checking bench: directed display scenarios plus random
//            stimulus compared against a frame-level behavioural model.
// Revision : 1.0 - initial release
// ============================================================================

module tb_vendor_display_scan;

    localparam int DW = 1;
    localparam int BH = 4;

    logic       clk = 1'b0;
    logic       rstn;
    logic [7:0] dis_price;
    logic [7:0] dis_money;
    logic [7:0] dis_returned;
    logic       flash;
    logic       lamp_test;
    logic [3:0] scan_en_0;
    logic [3:0] scan_en_1;
    logic [6:0] data_0_7seg;
    logic [6:0] data_1_7seg;

    int checks = 0;
    int errors = 0;

    // Model state: edges since reset release and the frame snapshot.
    int         n = 0;
    logic [7:0] sp = 8'h00;
    logic [7:0] sm = 8'h00;
    logic [7:0] sr = 8'h00;

    logic [6:0] seg_tab [0:9] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                  7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

    always #5 clk = ~clk;

    vendor_display_scan #(
        .DWELL      (DW),
        .BLINK_HALF (BH)
    ) u_dut (
        .clk_1kHz     (clk),
        .rstn         (rstn),
        .dis_price    (dis_price),
        .dis_money    (dis_money),
        .dis_returned (dis_returned),
        .flash        (flash),
        .lamp_test    (lamp_test),
        .scan_en_0    (scan_en_0),
        .scan_en_1    (scan_en_1),
        .data_0_7seg  (data_0_7seg),
        .data_1_7seg  (data_1_7seg)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (edge %0d)", tag, obs, exp, n);
        end
    endtask

    function automatic logic [6:0] digit_seg(input logic [3:0] d, input bit tens);
        if (d > 4'd9) return 7'h40;
        if (tens && d == 4'd0) return 7'h00;
        return seg_tab[d];
    endfunction

    // One clock edge: predict, clock, compare, then advance the model.
    task automatic cycle();
        logic [21:0] exp;
        logic [3:0]  en;
        logic [6:0]  s0;
        logic [6:0]  s1;
        int          ix;
        bit          ph;
        if (!rstn) begin
            exp = {4'hF, 4'hF, 7'h00, 7'h00};
        end else if (lamp_test) begin
            exp = {4'h0, 4'h0, 7'h7F, 7'h7F};
        end else begin
            ix = (n / DW) % 4;
            ph = ((n / BH) % 2) == 1;
            en = 4'b1111;
            en[ix] = 1'b0;
            case (ix)
                0:       s0 = digit_seg(sm[3:0], 1'b0);
                1:       s0 = digit_seg(sm[7:4], 1'b1);
                2:       s0 = digit_seg(sp[3:0], 1'b0);
                default: s0 = digit_seg(sp[7:4], 1'b1);
            endcase
            if (ix == 0)      s1 = digit_seg(sr[3:0], 1'b0);
            else if (ix == 1) s1 = digit_seg(sr[7:4], 1'b1);
            else              s1 = 7'h00;
            if (flash && ph) s1 = 7'h00;
            exp = {en, en, s1, s0};
        end
        @(posedge clk);
        #1;
        check("scan", {10'd0, scan_en_1, scan_en_0, data_1_7seg, data_0_7seg}, {10'd0, exp});
        if (!rstn) begin
            n  = 0;
            sp = 8'h00;
            sm = 8'h00;
            sr = 8'h00;
        end else begin
            if (n % (4 * DW) == 4 * DW - 1) begin
                sp = dis_price;
                sm = dis_money;
                sr = dis_returned;
            end
            n++;
        end
    endtask

    initial begin
        logic [6:0] exp0 [4] = '{7'h4F, 7'h00, 7'h5B, 7'h06};
        logic [6:0] exp1 [4] = '{7'h6F, 7'h00, 7'h00, 7'h00};

        rstn = 1'b0; dis_price = 8'h00; dis_money = 8'h00; dis_returned = 8'h00;
        flash = 1'b0; lamp_test = 1'b0;
        @(negedge clk);
        repeat (3) cycle();
        check("reset_en0", {28'd0, scan_en_0}, 32'hF);
        check("reset_seg0", {25'd0, data_0_7seg}, 32'h00);

        rstn = 1'b1;
        cycle();
        check("first_en0", {28'd0, scan_en_0}, 32'hE);
        check("first_seg0", {25'd0, data_0_7seg}, 32'h3F);
        check("first_seg1", {25'd0, data_1_7seg}, 32'h3F);

        dis_money = 8'h03; dis_price = 8'h12; dis_returned = 8'h09;
        repeat (3) cycle();
        for (int k = 0; k < 4; k++) begin
            cycle();
            check("frame_seg0", {25'd0, data_0_7seg}, {25'd0, exp0[k]});
            check("frame_seg1", {25'd0, data_1_7seg}, {25'd0, exp1[k]});
        end

        cycle();
        check("old_units", {25'd0, data_0_7seg}, 32'h4F);
        dis_money = 8'h25;
        repeat (3) cycle();
        cycle();
        check("new_units", {25'd0, data_0_7seg}, 32'h6D);
        cycle();
        check("new_tens", {25'd0, data_0_7seg}, 32'h5B);

        dis_price = 8'hA7;
        repeat (4) cycle();
        cycle();
        check("bad_units", {25'd0, data_0_7seg}, 32'h07);
        cycle();
        check("bad_tens", {25'd0, data_0_7seg}, 32'h40);

        flash = 1'b1;
        repeat (16) cycle();
        flash = 1'b0;
        repeat (2) cycle();

        lamp_test = 1'b1;
        cycle();
        check("lamp_en", {28'd0, scan_en_0}, 32'h0);
        check("lamp_seg", {25'd0, data_1_7seg}, 32'h7F);
        rstn = 1'b0;
        cycle();
        check("lamp_rst_en", {28'd0, scan_en_1}, 32'hF);
        check("lamp_rst_seg", {25'd0, data_0_7seg}, 32'h00);
        rstn = 1'b1;
        lamp_test = 1'b0;

        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 5) == 0) dis_price    = 8'($urandom);
            if ($urandom_range(0, 5) == 0) dis_money    = 8'($urandom);
            if ($urandom_range(0, 5) == 0) dis_returned = 8'($urandom);
            if ($urandom_range(0, 19) == 0) flash = ~flash;
            lamp_test = ($urandom_range(0, 19) == 0);
            rstn      = ($urandom_range(0, 99) != 0);
            cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
